// File: rtl/led_panel_pkg.sv
// led_panel_pkg: register offsets, CTRL bit positions and reset values shared
// by the led_panel peripheral and its optional PWM sub-module.
package led_panel_pkg;

  // Register offsets inside the 8-byte window (address[2:0]).
  localparam logic [2:0] OFF_DATA   = 3'd0;
  localparam logic [2:0] OFF_CTRL   = 3'd1;
  localparam logic [2:0] OFF_SET    = 3'd2;
  localparam logic [2:0] OFF_CLR    = 3'd3;
  localparam logic [2:0] OFF_BRIGHT = 3'd4;

  // CTRL register bit positions; only these two bits are implemented.
  localparam int CTRL_INVERT = 0;
  localparam int CTRL_BLANK  = 1;

  // Reset values.
  localparam logic [7:0] RST_LED    = 8'h00;
  localparam logic [1:0] RST_CTRL   = 2'b00;
  localparam logic [7:0] RST_BRIGHT = 8'hFF;
  localparam logic [7:0] RST_COUNT  = 8'h00;
  localparam logic [7:0] RST_LEDS   = 8'h00;

endpackage

// File: rtl/led_pwm.sv
// led_pwm: free-running 8-bit counter compared against a brightness level.
// bright = FF is treated as fully on so that the top level is never dimmed
// by one cycle in 256; bright = 00 is always off.
module led_pwm
  import led_panel_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] bright,
  output logic       pwm_on
);

  logic [7:0] count;

  // Counter increments every cycle and wraps naturally from FF to 00.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (reset) count <= RST_COUNT;
    else       count <= count + 8'd1;
  end

  // Duty-cycle compare against the current counter value.
  assign pwm_on = (bright == 8'hFF) || (count < bright);

endmodule

// File: rtl/led_panel.sv
// led_panel: memory-mapped 8-LED output peripheral on the CPU6 bus.
// Window of 8 bytes at BASE_ADDR (must be 8-byte aligned): DATA, CTRL, SET,
// CLR and, when LED_PANEL_PWM_EN is defined, BRIGHT with a PWM dimmer.
// Without LED_PANEL_PWM_EN the BRIGHT offset is reserved and LEDs are full on.
module led_panel
  import led_panel_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hF110
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [7:0]  leds
);

  logic       selected;
  logic [2:0] offset;
  logic       wr;
  logic [7:0] led_reg;
  logic [1:0] ctrl_reg;
  logic [7:0] pattern;
  logic       pwm_on;

  // Only the upper 13 address bits take part in decode; BASE_ADDR[2:0] is
  // assumed zero.
  assign selected = (address[15:3] == BASE_ADDR[15:3]);
  assign offset   = address[2:0];
  assign wr       = selected && write_en;

`ifdef LED_PANEL_PWM_EN
  logic [7:0] bright_reg;

  // BRIGHT register, reset to full brightness.
  always_ff @(posedge clock) begin
    if (reset)                           bright_reg <= RST_BRIGHT;
    else if (wr && offset == OFF_BRIGHT) bright_reg <= data_in;
  end

  led_pwm u_pwm (
    .clock  (clock),
    .reset  (reset),
    .bright (bright_reg),
    .pwm_on (pwm_on)
  );
`else
  assign pwm_on = 1'b1;
`endif

  // DATA/SET/CLR share led_reg; SET and CLR are single-cycle read-modify-write.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_reg  <= RST_LED;
      ctrl_reg <= RST_CTRL;
    end else if (wr) begin
      case (offset)
        OFF_DATA: led_reg  <= data_in;
        OFF_CTRL: ctrl_reg <= data_in[1:0];
        OFF_SET:  led_reg  <= led_reg | data_in;
        OFF_CLR:  led_reg  <= led_reg & ~data_in;
        default:  ;
      endcase
    end
  end

  assign pattern = ctrl_reg[CTRL_BLANK] ? 8'h00
                                        : (led_reg ^ {8{ctrl_reg[CTRL_INVERT]}});

  // LED pins are registered, giving one cycle of latency after a write.
  always_ff @(posedge clock) begin
    if (reset) leds <= RST_LEDS;
    else       leds <= pattern & {8{pwm_on}};
  end

  // Combinational read mux from current (pre-write) register state.
  always_comb begin
    // NOTE: default assigned first so every path drives data_out and no
    // latch is inferred for unlisted offsets.
    data_out = 8'h00;
    if (selected) begin
      case (offset)
        OFF_DATA, OFF_SET, OFF_CLR: data_out = led_reg;
        OFF_CTRL:                   data_out = {6'b0, ctrl_reg};
`ifdef LED_PANEL_PWM_EN
        OFF_BRIGHT:                 data_out = bright_reg;
`endif
        default:                    data_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_led_panel.sv
// tb_led_panel: directed self-checking bench for led_panel.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_led_panel;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [7:0]  leds;

  int vectors = 0;
  int miscompares = 0;

  led_panel #(.BASE_ADDR(16'hF110)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .leds     (leds)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One bus write; returns on the falling edge after the write edge.
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    address  = a;
    data_in  = d;
    write_en = 1'b1;
    @(negedge clock);
    write_en = 1'b0;
  endtask

  // Combinational read at the current time (no clock edge consumed).
  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    address = a;
    #1;
    d = data_out;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  logic [7:0] rd;

  initial begin
    reset    = 1'b1;
    address  = 16'h0000;
    write_en = 1'b0;
    data_in  = 8'h00;

    // Reset for two cycles.
    step(); step();
    check("reset_leds", leds, 8'h00);
    bus_read(16'hF110, rd); check("reset_data", rd, 8'h00);
    bus_read(16'hF111, rd); check("reset_ctrl", rd, 8'h00);
`ifdef LED_PANEL_PWM_EN
    bus_read(16'hF114, rd); check("reset_bright", rd, 8'hFF);
`endif
    reset = 1'b0;

    // DATA write: register updates at the edge, leds one cycle later.
    bus_write(16'hF110, 8'hA5);
    bus_read(16'hF110, rd); check("data_readback", rd, 8'hA5);
    check("leds_latency", leds, 8'h00);
    step();
    check("leds_data", leds, 8'hA5);

    // Outside the window: nothing changes, read returns 00.
    bus_write(16'hF118, 8'h00);
    bus_read(16'hF118, rd); check("outside_read", rd, 8'h00);
    step();
    check("outside_leds", leds, 8'hA5);
    bus_read(16'hF10F, rd); check("below_read", rd, 8'h00);

    // SET: read during the write cycle returns the pre-write value.
    @(negedge clock);
    address = 16'hF112; data_in = 8'h0F; write_en = 1'b1;
    #1; check("set_prewrite_read", data_out, 8'hA5);
    @(negedge clock);
    write_en = 1'b0;
    bus_read(16'hF112, rd); check("set_readback", rd, 8'hAF);
    step();
    check("leds_set", leds, 8'hAF);

    // CLR.
    bus_write(16'hF113, 8'hA0);
    bus_read(16'hF110, rd); check("clr_readback", rd, 8'h0F);
    step();
    check("leds_clr", leds, 8'h0F);

    // Reserved offsets 5..7 read 00 and ignore writes.
    bus_write(16'hF115, 8'hFF);
    bus_read(16'hF115, rd); check("rsv5_read", rd, 8'h00);
    bus_write(16'hF117, 8'hFF);
    bus_read(16'hF117, rd); check("rsv7_read", rd, 8'h00);
    bus_read(16'hF116, rd); check("rsv6_read", rd, 8'h00);
    bus_read(16'hF110, rd); check("rsv_data_kept", rd, 8'h0F);
    step();
    check("rsv_leds", leds, 8'h0F);

    // CTRL: invert, blank, clear; upper bits not stored.
    bus_write(16'hF111, 8'h01);
    bus_read(16'hF111, rd); check("ctrl_inv_read", rd, 8'h01);
    step();
    check("leds_invert", leds, 8'hF0);
    bus_write(16'hF111, 8'hFE);
    bus_read(16'hF111, rd); check("ctrl_mask_read", rd, 8'h02);
    step();
    check("leds_blank", leds, 8'h00);
    bus_write(16'hF111, 8'h03);
    bus_read(16'hF111, rd); check("ctrl_03_read", rd, 8'h03);
    step();
    check("leds_blank_inv", leds, 8'h00);
    bus_write(16'hF111, 8'h00);
    step();
    check("leds_ctrl_clear", leds, 8'h0F);

`ifndef LED_PANEL_PWM_EN
    // BRIGHT offset is reserved without PWM.
    bus_write(16'hF114, 8'h12);
    bus_read(16'hF114, rd); check("bright_absent", rd, 8'h00);
    step();
    check("bright_absent_leds", leds, 8'h0F);
`endif

    // Reset wins over a simultaneous DATA write.
    @(negedge clock);
    address = 16'hF110; data_in = 8'h3C; write_en = 1'b1; reset = 1'b1;
    @(negedge clock);
    write_en = 1'b0;
    bus_read(16'hF110, rd); check("reset_over_write", rd, 8'h00);
    check("reset_mid_leds", leds, 8'h00);
    reset = 1'b0;
    step();
    check("post_reset_leds", leds, 8'h00);

`ifdef LED_PANEL_PWM_EN
    begin
      int on_cnt;
      int off_cnt;
      bus_write(16'hF110, 8'hFF);
      bus_write(16'hF114, 8'h40);
      bus_read(16'hF114, rd); check("bright_readback", rd, 8'h40);
      step(); step();
      on_cnt = 0; off_cnt = 0;
      for (int i = 0; i < 256; i++) begin
        step();
        if (leds === 8'hFF) on_cnt++;
        else if (leds === 8'h00) off_cnt++;
      end
      check("pwm40_on", 8'(on_cnt), 8'd64);
      check("pwm40_off", 8'(off_cnt), 8'd192);

      bus_write(16'hF114, 8'h00);
      step(); step();
      on_cnt = 0;
      for (int i = 0; i < 256; i++) begin
        step();
        if (leds !== 8'h00) on_cnt++;
      end
      check("pwm00_nonzero", 8'(on_cnt), 8'd0);

      bus_write(16'hF114, 8'hFF);
      step(); step();
      off_cnt = 0;
      for (int i = 0; i < 256; i++) begin
        step();
        if (leds !== 8'hFF) off_cnt++;
      end
      check("pwmFF_not_full", 8'(off_cnt), 8'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
